muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M-style multiply/divide unit, parametrised in data width.
- Companion to the single-cycle ALU: the decoder issues M-extension ops here and stalls the core until the result is back.
- Uses a valid/ready handshake on input and output, one bit-step per cycle, with single-cycle fast paths for the RISC-V divide corner cases.
- Contains a state machine, an iteration counter and result buffering.

Parameters:
- XLEN, 32, operand/result width (>=8, power of two).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- flush  in  1  abort current op (pipeline kill), synchronous.
- in_valid  in  1  op request valid.
- in_ready  out  1  unit can accept an op (high only in IDLE).
- op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  registered result.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- One clock; reset is synchronous and active-low. rstn low at an edge: state=IDLE, out_valid=0, result=0, counter=0, internal regs=0, in_ready=1 after that edge. Reset dominates flush and all handshakes.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready.
  - Latch op, |a|, |b| (magnitudes for signed operand positions, per op signedness) and result sign.
  - Normal path -> BUSY with counter=0.
  - Fast path -> DONE directly, result written that edge. Fast path covers:
    - Divide by zero: DIV/DIVU result all-ones; REM/REMU result = a.
    - Signed overflow (DIV/REM with a=most-negative, b=-1): DIV result = a; REM result = 0.
- BUSY, multiply:
  - Shift-add over a 2*XLEN accumulator, one multiplier bit per cycle.
  - MULHSU treats a as signed and b as unsigned.
- BUSY, divide:
  - Restoring divide, one quotient bit per cycle.
  - Remainder sign follows dividend; quotient sign = sign(a) xor sign(b) for signed ops.
- BUSY counter:
  - Increments each cycle.
  - At counter==XLEN-1 the edge applies sign fix-up, writes result and goes to DONE.
- Latency: normal ops give out_valid high exactly XLEN+1 cycles after the accepting edge. Fast path gives out_valid 1 cycle after.
- Result selection: MUL takes the low XLEN of the product; MULH/MULHSU/MULHU take the high XLEN.
- DONE:
  - out_valid=1; result held stable until out_valid&&out_ready.
  - On that edge -> IDLE, out_valid=0.
  - in_ready=0 in DONE, so a new op is accepted no earlier than the cycle after the handshake.
- Input stability: in_valid without in_ready (BUSY/DONE) is ignored. Operands are only sampled on accept, so a/b may change freely while BUSY.
- flush:
  - In any state, flush at an edge -> IDLE, out_valid=0; result keeps its last value.
  - flush and in_valid together in IDLE: flush wins, op not accepted.
  - flush coinciding with the out handshake: flush wins, net state IDLE.
- All arithmetic is modulo 2^XLEN. No X-propagation from unused op codes (all 8 are defined).

Test Plan:
- Reset/idle: hold rstn=0 for 3 cycles with in_valid=1 -> out_valid=0, result=0, in_ready=1 after release, no op accepted during reset.
- Multiply set (XLEN=32):
  - MUL a=7, b=0xFFFFFFFD -> 0xFFFFFFEB; out_valid exactly 33 cycles after accept.
  - MULH a=b=0x80000000 -> 0x40000000.
  - MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- Divide set:
  - DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU a=100, b=7 -> 14.
  - REMU same operands -> 2.
- Corner fast paths:
  - DIVU a=5, b=0 -> 0xFFFFFFFF.
  - REM a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
  - Each fast-path case gives out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result/out_valid stable, in_ready=0 and in_valid ignored. Release -> IDLE next cycle, then accept a back-to-back op.
- Flush/reset mid-op:
  - Assert flush at BUSY counter=10 -> IDLE next cycle, out_valid never asserted; the following MUL 3*4 returns 12.
  - Repeat with rstn=0 instead of flush -> same, plus result=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with single-cycle results for divide-by-zero and signed overflow.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]        state_q;
   logic [2:0]        op_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   bb_q;
   logic              neg_q;

   logic              a_sgn, b_sgn;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              neg_in, div_zero, div_ovf, fast;
   logic [XLEN-1:0]   fast_res;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_sh, div_diff;
   logic [2*XLEN-1:0] acc_next, prod_fix;
   logic [XLEN-1:0]   quo, rem, fin_res;

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);

   // Operand conditioning at accept: magnitudes for signed positions and result sign.
   always_comb begin
      a_sgn    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
      b_sgn    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
      a_mag    = (a_sgn && a[XLEN-1]) ? -a : a;
      b_mag    = (b_sgn && b[XLEN-1]) ? -b : b;
      div_zero = op[2] && (b == '0);
      div_ovf  = ((op == 3'd4) || (op == 3'd6)) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
      fast     = div_zero || div_ovf;
      if (div_zero) fast_res = op[1] ? a : '1;
      else          fast_res = op[1] ? '0 : a;
      unique case (op)
         3'd1:    neg_in = a[XLEN-1] ^ b[XLEN-1];
         3'd2:    neg_in = a[XLEN-1];
         3'd4:    neg_in = a[XLEN-1] ^ b[XLEN-1];
         3'd6:    neg_in = a[XLEN-1];
         default: neg_in = 1'b0;
      endcase
   end

   // One iteration step; acc holds {partial, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, bb_q} : '0);
      div_sh   = acc_q[2*XLEN-1:XLEN-1];
      div_diff = div_sh - {1'b0, bb_q};
      if (!op_q[2])        acc_next = {mul_sum, acc_q[XLEN-1:1]};
      else if (div_diff[XLEN]) acc_next = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else                 acc_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      prod_fix = neg_q ? -acc_next : acc_next;
      quo      = acc_next[XLEN-1:0];
      rem      = acc_next[2*XLEN-1:XLEN];
      unique case (op_q)
         3'd0:    fin_res = prod_fix[XLEN-1:0];
         3'd1,
         3'd2,
         3'd3:    fin_res = prod_fix[2*XLEN-1:XLEN];
         3'd4:    fin_res = neg_q ? -quo : quo;
         3'd5:    fin_res = quo;
         3'd6:    fin_res = neg_q ? -rem : rem;
         default: fin_res = rem;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         bb_q    <= '0;
         neg_q   <= 1'b0;
         result  <= '0;
      end else if (flush) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q  <= op;
                  neg_q <= neg_in;
                  cnt_q <= '0;
                  if (fast) begin
                     result  <= fast_res;
                     state_q <= ST_DONE;
                  end else begin
                     acc_q   <= {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
                     bb_q    <= op[2] ? b_mag : a_mag;
                     state_q <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               acc_q <= acc_next;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(XLEN-1)) begin
                  result  <= fin_res;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32): arithmetic vectors,
// latency, fast paths, backpressure, flush and reset during an operation.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rstn, flush, in_valid, out_ready;
   logic        in_ready, out_valid, busy;
   logic [2:0]  op;
   logic [31:0] a, b, result;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Called #1 after an edge; presents one op for exactly one edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h1234_5678;
   endtask

   // Cycles from the accepting edge until out_valid is seen, bounded.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
      int lat;
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
      issue(o, x, y);
      wait_valid(lat);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check(tag, result, exp);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_idle"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      int seen;
      rstn = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      op = 3'd0; a = 32'd3; b = 32'd4;

      // Reset held with a pending request
      repeat (3) begin
         @(posedge clk); #1;
         check("rst_valid", 32'(out_valid), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
      end
      check("rst_result", result, 32'd0);
      in_valid = 1'b0;
      rstn = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_no_accept", 32'(out_valid), 32'd0);

      // Multiply
      run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      run_op("mulh_mix", 3'd1, 32'hFFFF_FFFE, 32'd3,      32'hFFFF_FFFF, 33);

      // Divide
      run_op("div",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_op("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_op("divu", 3'd5, 32'd100,       32'd7, 32'd14,        33);
      run_op("remu", 3'd7, 32'd100,       32'd7, 32'd2,         33);
      run_op("div_pn", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);

      // Fast paths
      run_op("divu_z",  3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run_op("div_z",   3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run_op("rem_z",   3'd6, 32'd5,         32'd0,         32'd5,         1);
      run_op("remu_z",  3'd7, 32'd9,         32'd0,         32'd9,         1);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

      // Backpressure in DONE with a competing request
      issue(3'd5, 32'd100, 32'd7);
      wait_valid(lat);
      check("bp_lat", 32'(lat), 32'd33);
      op = 3'd0; a = 32'd2; b = 32'd2; in_valid = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_result", result, 32'd14);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release_idle", 32'(in_ready), 32'd1);
      check("bp_release_valid", 32'(out_valid), 32'd0);
      run_op("b2b_remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);

      // Flush beats a request in IDLE
      op = 3'd0; a = 32'd5; b = 32'd5; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush_idle_busy", 32'(busy), 32'd0);
      check("flush_idle_ready", 32'(in_ready), 32'd1);

      // Flush at BUSY counter==10
      issue(3'd5, 32'd100, 32'd7);
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_ready", 32'(in_ready), 32'd1);
      check("flush_busy", 32'(busy), 32'd0);
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("flush_no_valid", 32'(seen), 32'd0);
      check("flush_result_kept", result, 32'd2);
      run_op("flush_mul", 3'd0, 32'd3, 32'd4, 32'd12, 33);

      // Reset at BUSY counter==10
      issue(3'd4, 32'hFFFF_FFF9, 32'd2);
      repeat (10) @(posedge clk);
      #1 rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      check("rstop_ready", 32'(in_ready), 32'd1);
      check("rstop_result", result, 32'd0);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("rstop_no_valid", 32'(seen), 32'd0);
      run_op("rstop_mul", 3'd0, 32'd3, 32'd4, 32'd12, 33);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
